dbus_sram_responder: RTL

//   Responder (slave) end of the data bus: accepts one dbus_req_t from the memory-stage

---
 rtl/common.sv | 33 +++
 rtl/dbus_strobe_merge.sv | 18 +
 rtl/dbus_sram_responder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/common.sv
// Shared data-bus types used by the memory stage, its responders and the caches.
package common;

  localparam int unsigned ADDR_W   = 64;
  localparam int unsigned WORD_W   = 64;
  localparam int unsigned STROBE_W = WORD_W / 8;

  typedef logic [ADDR_W-1:0]   addr_t;
  typedef logic [WORD_W-1:0]   word_t;
  typedef logic [STROBE_W-1:0] strobe_t;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef struct packed {
    logic    valid;
    addr_t   addr;
    msize_t  size;
    strobe_t strobe;
    word_t   data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

endpackage

// File: rtl/dbus_strobe_merge.sv
// Byte-strobed merge of new data into an existing word; purely combinational.
module dbus_strobe_merge
  import common::*;
(
  input  word_t   old_word,
  input  word_t   new_data,
  input  strobe_t strobe,
  output word_t   merged_c
);

  always_comb begin
    merged_c = old_word;
    for (int i = 0; i < int'(STROBE_W); i++) begin
      if (strobe[i]) merged_c[8*i +: 8] = new_data[8*i +: 8];
    end
  end

endmodule

// File: rtl/dbus_sram_responder.sv
// Data-bus responder backed by a word-wide SRAM array with a fixed response latency.
module dbus_sram_responder
  import common::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter addr_t       BASE_ADDR   = 64'h8000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       oob,
  output logic       busy
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  addr_t            addr_q;
  msize_t           size_q;
  strobe_t          strobe_q;
  word_t            data_q;

  word_t mem [DEPTH_WORDS];

  addr_t            acc_addr;
  msize_t           acc_size;
  strobe_t          acc_strobe;
  word_t            acc_data;
  addr_t            offset;
  logic             misalign;
  logic             reject;
  logic             access;
  logic             write_en;
  logic [IDX_W-1:0] index;
  word_t            old_word;
  word_t            merged;

  // With LATENCY==1 the access happens on the accept edge, so use the live request.
  always_comb begin
    if (state == IDLE) begin
      acc_addr   = dreq.addr;
      acc_size   = dreq.size;
      acc_strobe = dreq.strobe;
      acc_data   = dreq.data;
    end else begin
      acc_addr   = addr_q;
      acc_size   = size_q;
      acc_strobe = strobe_q;
      acc_data   = data_q;
    end
  end

  always_comb begin
    misalign = 1'b0;
    case (acc_size)
      MSIZE2:  misalign = acc_addr[0];
      MSIZE4:  misalign = |acc_addr[1:0];
      MSIZE8:  misalign = |acc_addr[2:0];
      default: misalign = 1'b0;
    endcase
  end

  // Range check at full address width; the index is only narrowed afterwards.
  always_comb begin
    offset   = acc_addr - BASE_ADDR;
    reject   = (acc_addr < BASE_ADDR) || ((offset >> 3) >= ADDR_W'(DEPTH_WORDS)) || misalign;
    index    = offset[IDX_W+2:3];
    access   = ((state == IDLE) && dreq.valid && (LATENCY == 1)) ||
               ((state == WAIT) && (cnt == CNT_W'(1)));
    write_en = rst && access && !reject && (|acc_strobe);
  end

  assign old_word = mem[index];

  dbus_strobe_merge u_merge (
    .old_word (old_word),
    .new_data (acc_data),
    .strobe   (acc_strobe),
    .merged_c (merged)
  );

  // Array contents survive reset; write_en already excludes reset edges.
  always_ff @(posedge clk) begin
    if (write_en) mem[index] <= merged;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      size_q   <= MSIZE1;
      strobe_q <= '0;
      data_q   <= '0;
      dresp    <= '0;
      oob      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      dresp <= '0;
      oob   <= 1'b0;
      case (state)
        IDLE: begin
          if (dreq.valid) begin
            addr_q   <= dreq.addr;
            size_q   <= dreq.size;
            strobe_q <= dreq.strobe;
            data_q   <= dreq.data;
            cnt      <= CNT_LOAD;
            busy     <= 1'b1;
            state    <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= RESP;
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
      // Response word is the pre-write contents; rejected requests return zero.
      if (access) begin
        dresp.addr_ok <= 1'b1;
        dresp.data_ok <= 1'b1;
        dresp.data    <= reject ? '0 : old_word;
        oob           <= reject;
      end
    end
  end

endmodule
